// File: rtl/seq_alu.sv
// seq_alu: registered execute-stage ALU with a valid/ready handshake.
//   Single-cycle ops (shifts, add/sub, logic, set-less-than) produce a
//   result one cycle after accept. MULT/MULTU use a radix-2 shift-add on
//   operand magnitudes and DIV/DIVU use restoring division. Both run WIDTH
//   iteration steps before the result is presented.
//
// Ports:
//   CLK, RST           clock, synchronous active-high reset
//   in_valid/in_ready  request handshake (in_ready high only while idle)
//   aluop              opcode 0..15 (see localparams below)
//   port_a, port_b     operands, latched at accept
//   out_valid/out_ready result handshake; results hold until taken
//   result_lo          result / product low / quotient
//   result_hi          product high / remainder, 0 for single-cycle ops
//   overflow           signed overflow (ADD/SUB, DIV of min by -1)
//   negative, zero     flags derived from the final result_lo
//   div_by_zero        divide with port_b == 0
module seq_alu #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       aluop,
  input  logic [WIDTH-1:0] port_a,
  input  logic [WIDTH-1:0] port_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             overflow,
  output logic             negative,
  output logic             zero,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [3:0] OP_SLL   = 4'd0;
  localparam logic [3:0] OP_SRL   = 4'd1;
  localparam logic [3:0] OP_SRA   = 4'd2;
  localparam logic [3:0] OP_ADD   = 4'd3;
  localparam logic [3:0] OP_SUB   = 4'd4;
  localparam logic [3:0] OP_AND   = 4'd5;
  localparam logic [3:0] OP_OR    = 4'd6;
  localparam logic [3:0] OP_XOR   = 4'd7;
  localparam logic [3:0] OP_NOR   = 4'd8;
  localparam logic [3:0] OP_SLT   = 4'd9;
  localparam logic [3:0] OP_SLTU  = 4'd10;
  localparam logic [3:0] OP_MULT  = 4'd11;
  localparam logic [3:0] OP_MULTU = 4'd12;
  localparam logic [3:0] OP_DIV   = 4'd13;
  localparam logic [3:0] OP_DIVU  = 4'd14;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state, state_nx;

  // Absolute value when the operand is treated as signed. The most-negative
  // value maps to 2^(WIDTH-1), which is still correct as an unsigned magnitude.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic sgn);
    return (sgn && v[WIDTH-1]) ? -v : v;
  endfunction

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v,
                                                input logic neg);
    return neg ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_neg2(input logic [2*WIDTH-1:0] v,
                                                   input logic neg);
    return neg ? -v : v;
  endfunction

  // Signed overflow: for ADD the operand signs match, for SUB they differ,
  // and in both cases the result sign differs from A.
  function automatic logic add_ovf(input logic sgn_a, input logic sgn_b,
                                   input logic sgn_r, input logic is_sub);
    return is_sub ? ((sgn_a != sgn_b) && (sgn_r != sgn_a))
                  : ((sgn_a == sgn_b) && (sgn_r != sgn_a));
  endfunction

  logic accept;
  logic is_mul, is_div, mul_signed, div_signed;
  logic [CW-1:0] cnt;
  logic last;

  assign in_ready   = (state == IDLE) & ~RST;
  assign accept     = in_valid & in_ready;
  assign out_valid  = (state == DONE);
  assign mul_signed = (aluop == OP_MULT);
  assign div_signed = (aluop == OP_DIV);
  assign is_mul     = (aluop == OP_MULT) || (aluop == OP_MULTU);
  assign is_div     = (aluop == OP_DIV)  || (aluop == OP_DIVU);
  assign last       = (cnt == CW'(1));

  // ---------------------------------------------------------------------
  // Single-cycle datapath, evaluated from the live inputs at accept
  // ---------------------------------------------------------------------
  logic signed [WIDTH-1:0] sa, sb;
  logic [WIDTH-1:0] sum, diff, sc_lo;
  logic [SHW-1:0]   shamt;
  logic             sc_ovf;

  assign sa    = port_a;
  assign sb    = port_b;
  assign shamt = port_b[SHW-1:0];
  assign sum   = port_a + port_b;
  assign diff  = port_a - port_b;

  always_comb begin
    sc_lo  = '0;
    sc_ovf = 1'b0;
    case (aluop)
      OP_SLL:  sc_lo = port_a << shamt;
      OP_SRL:  sc_lo = port_a >> shamt;
      OP_SRA:  sc_lo = sa >>> shamt;
      OP_ADD: begin
        sc_lo  = sum;
        sc_ovf = add_ovf(port_a[WIDTH-1], port_b[WIDTH-1], sum[WIDTH-1], 1'b0);
      end
      OP_SUB: begin
        sc_lo  = diff;
        sc_ovf = add_ovf(port_a[WIDTH-1], port_b[WIDTH-1], diff[WIDTH-1], 1'b1);
      end
      OP_AND:  sc_lo = port_a & port_b;
      OP_OR:   sc_lo = port_a | port_b;
      OP_XOR:  sc_lo = port_a ^ port_b;
      OP_NOR:  sc_lo = ~(port_a | port_b);
      OP_SLT:  sc_lo[0] = (sa < sb);
      OP_SLTU: sc_lo[0] = (port_a < port_b);
      default: sc_lo = '0;
    endcase
  end

  // ---------------------------------------------------------------------
  // Iterative datapath working registers
  //   mcand : multiplicand magnitude / divisor magnitude
  //   acc   : partial product high half / partial remainder
  //   mq    : multiplier being consumed / dividend shifting into quotient
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0] mcand, acc, mq, a_lat;
  logic             neg_lo, neg_hi, sdiv_ovf, dz_lat;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_acc_nx, mul_mq_nx;
  logic [WIDTH:0]   div_shift, div_trial;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem_nx, div_mq_nx;

  // Shift-add step: add the multiplicand when the current multiplier bit is
  // set, then shift {carry, acc, mq} right by one.
  assign mul_sum    = {1'b0, acc} + (mq[0] ? {1'b0, mcand} : '0);
  assign mul_acc_nx = mul_sum[WIDTH:1];
  assign mul_mq_nx  = {mul_sum[0], mq[WIDTH-1:1]};

  // Restoring step: bring the next dividend bit into the remainder and keep
  // the trial subtraction only when it does not go negative.
  assign div_shift  = {acc, mq[WIDTH-1]};
  assign div_trial  = div_shift - {1'b0, mcand};
  assign div_ge     = ~div_trial[WIDTH];
  assign div_rem_nx = div_ge ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
  assign div_mq_nx  = {mq[WIDTH-2:0], div_ge};

  always_ff @(posedge CLK) begin
    if (accept && is_mul) begin
      mcand  <= magnitude(port_a, mul_signed);
      mq     <= magnitude(port_b, mul_signed);
      acc    <= '0;
      neg_lo <= mul_signed && (port_a[WIDTH-1] ^ port_b[WIDTH-1]);
      neg_hi <= 1'b0;
    end else if (accept && is_div) begin
      mq     <= magnitude(port_a, div_signed);
      mcand  <= magnitude(port_b, div_signed);
      acc    <= '0;
      neg_lo <= div_signed && (port_a[WIDTH-1] ^ port_b[WIDTH-1]);
      neg_hi <= div_signed && port_a[WIDTH-1];
    end else if (state == MUL) begin
      acc <= mul_acc_nx;
      mq  <= mul_mq_nx;
    end else if (state == DIV) begin
      acc <= div_rem_nx;
      mq  <= div_mq_nx;
    end
    if (accept) begin
      a_lat    <= port_a;
      dz_lat   <= is_div && (port_b == '0);
      sdiv_ovf <= div_signed && (port_a == {1'b1, {(WIDTH-1){1'b0}}})
                             && (port_b == '1);
    end
  end

  // Final result formed from the last step's combinational outputs so the
  // result registers load on the same edge the counter reaches zero.
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   fin_lo, fin_hi;
  logic               fin_ovf, fin_dz;

  assign prod = cond_neg2({mul_acc_nx, mul_mq_nx}, neg_lo);

  always_comb begin
    fin_lo  = '0;
    fin_hi  = '0;
    fin_ovf = 1'b0;
    fin_dz  = 1'b0;
    if (state == MUL) begin
      fin_lo = prod[WIDTH-1:0];
      fin_hi = prod[2*WIDTH-1:WIDTH];
    end else if (dz_lat) begin
      fin_lo = '1;
      fin_hi = a_lat;
      fin_dz = 1'b1;
    end else begin
      fin_lo  = cond_neg(div_mq_nx, neg_lo);
      fin_hi  = cond_neg(div_rem_nx, neg_hi);
      fin_ovf = sdiv_ovf;
    end
  end

  // ---------------------------------------------------------------------
  // Result registers and step counter
  // ---------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt         <= '0;
      result_lo   <= '0;
      result_hi   <= '0;
      overflow    <= 1'b0;
      negative    <= 1'b0;
      zero        <= 1'b0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      if (is_mul || is_div) begin
        cnt <= CW'(WIDTH);
      end else begin
        cnt         <= '0;
        result_lo   <= sc_lo;
        result_hi   <= '0;
        overflow    <= sc_ovf;
        negative    <= sc_lo[WIDTH-1];
        zero        <= (sc_lo == '0);
        div_by_zero <= 1'b0;
      end
    end else if ((state == MUL) || (state == DIV)) begin
      cnt <= cnt - CW'(1);
      if (last) begin
        result_lo   <= fin_lo;
        result_hi   <= fin_hi;
        overflow    <= fin_ovf;
        negative    <= fin_lo[WIDTH-1];
        zero        <= (fin_lo == '0);
        div_by_zero <= fin_dz;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (is_mul)      state_nx = MUL;
          else if (is_div) state_nx = DIV;
          else             state_nx = DONE;
        end
      end
      MUL, DIV: begin
        if (last) state_nx = DONE;
      end
      DONE: begin
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, registered successor to the single-cycle datapath ALU.
- Performs all single-cycle ops (shift, add/sub, logic, set-less-than) plus iterative signed/unsigned multiply and divide, all behind a valid/ready handshake.
- Sits in the execute stage; the hazard unit stalls the pipeline while in_ready is low or out_valid is pending.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a power of two, at least 8.
- SHW, $clog2(WIDTH), shift-amount bits taken from port_b.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RST  input  1  reset, synchronous, active-high.
- in_valid  input  1  operation request.
- in_ready  output  1  block can accept; high only in IDLE.
- aluop  input  4  opcode: 0 SLL, 1 SRL, 2 SRA, 3 ADD, 4 SUB, 5 AND, 6 OR, 7 XOR, 8 NOR, 9 SLT, 10 SLTU, 11 MULT, 12 MULTU, 13 DIV, 14 DIVU, 15 reserved.
- port_a  input  WIDTH  operand A.
- port_b  input  WIDTH  operand B.
- out_valid  output  1  result registers valid.
- out_ready  input  1  consumer takes result.
- result_lo  output  WIDTH  main result / product low / quotient.
- result_hi  output  WIDTH  product high / remainder; 0 for single-cycle ops.
- overflow  output  1  signed overflow.
- negative  output  1  result_lo[WIDTH-1].
- zero  output  1  result_lo == 0.
- div_by_zero  output  1  divide with port_b == 0.

Behaviour:
- States: IDLE, MUL, DIV, DONE.
- Reset: state IDLE; in_ready=1. out_valid, result_lo, result_hi, overflow, negative, zero, div_by_zero and the internal counter all 0.
- RST mid-operation aborts and discards the operation; the next cycle is IDLE.
- Accept occurs when in_valid & in_ready on a rising edge; operands and opcode are latched.
- aluop/port_a/port_b are ignored when not accepted.
- in_valid is ignored outside IDLE; no queueing.
- Single-cycle ops (0-10, 15): the result is computed from the inputs at the accept edge and registered; state goes IDLE->DONE. out_valid is high the cycle after accept (latency 1).
- Shifts: port_a is shifted by port_b[SHW-1:0]. SRA replicates port_a[WIDTH-1].
- ADD/SUB: WIDTH-bit wraparound. overflow = signed overflow: operand signs match (ADD) or differ (SUB), and the result sign differs from A.
- SLT is a signed compare; SLTU is an unsigned compare. Both yield 1 or 0.
- Reserved opcode 15 yields result_lo=0, which sets zero=1.
- MULT/MULTU: radix-2 shift-add on operand magnitudes. The signed product is negated if the operand signs differ. {result_hi,result_lo} = full 2*WIDTH product; overflow=0.
- DIV/DIVU: restoring division, one quotient bit per cycle.
  - Signed DIV operates on magnitudes. Quotient is negated if the signs differ; remainder takes the sign of A (truncation toward zero).
  - Signed DIV with A = most-negative and B = -1: quotient = most-negative, remainder 0, overflow=1.
- Iterative timing: after the accept edge the counter is loaded with WIDTH. One step per cycle in MUL/DIV. The step at which the counter reaches 0 writes final results and moves to DONE. out_valid is first high WIDTH cycles after accept.
- Divide by zero still takes the WIDTH cycles. Outputs: div_by_zero=1, result_lo = all ones, result_hi = port_a as latched; this holds for both signed and unsigned.
- div_by_zero is 0 for all other ops.
- Flags: zero and negative always derive from the final result_lo.
- All outputs hold stable throughout DONE.
- DONE: out_valid=1. When out_ready is high on an edge, go to IDLE and clear out_valid (result registers keep their values).
- If out_ready is already high when DONE is entered, DONE lasts exactly one cycle.
- Back-to-back throughput: at most one accept per 2 cycles for single-cycle ops.
- in_ready = (state == IDLE) & ~RST.

Test Plan:
- Reset, then ADD with WIDTH=32, A=0x7FFFFFFF, B=1 -> one cycle later out_valid=1, result_lo=0x80000000, overflow=1, negative=1, zero=0. With out_ready=1, next cycle IDLE and in_ready=1.
- SUB A=5, B=5; SLT A=0xFFFFFFFF, B=1; SLTU with the same operands -> 0 with zero=1; 1; 0 respectively. SRA A=0x80000000 by B=4 -> 0xF8000000.
- MULT A=-3 (0xFFFFFFFD), B=7 -> exactly 32 cycles after accept: hi=0xFFFFFFFF, lo=0xFFFFFFEB. MULTU of the same operands -> hi=0x00000006, lo=0xFFFFFFEB.
- DIV A=-7, B=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU 100/7 -> lo=14, hi=2. DIV 0x80000000 by -1 -> lo=0x80000000, hi=0, overflow=1.
- DIVU A=9, B=0 -> after 32 cycles: div_by_zero=1, lo=0xFFFFFFFF, hi=9. Hold out_ready=0 for 5 cycles -> outputs stable, in_ready=0, in_valid pulses ignored.
- Assert RST at cycle 10 of a MULT -> next cycle all outputs 0, in_ready=1. A fresh ADD 2+3 then returns 5 with no residue. Repeat with WIDTH=8: MULTU 0xFF*0xFF -> hi=0xFE, lo=0x01 after 8 cycles.
